bat_amateur_loader: RTL and testbench

Program loader that sits directly upstream of the `bat_amateur` core and fills its RAM through the external-access port. On a start request it asserts `HALT` and accepts a stream of 16-bit words over a valid/ready handshake. It writes each word to consecutive RAM addresses, then pulses a core reset and releases `HALT`. The core then runs the loaded program from address 0.

---
 rtl/bat_amateur_loader.sv | 153 +++++++++++++++
 tb/tb_bat_amateur_loader.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/bat_amateur_loader.sv
// Program loader for the bat_amateur core: halts the core, streams words into its RAM
// through the external-access port, then pulses the core reset and releases HALT.
module bat_amateur_loader #(
  parameter int unsigned MAX_WORDS  = 256,
  parameter logic        RW_WRITE   = 1'b1,
  parameter int unsigned RST_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [15:0] LEN,
  input  logic [15:0] START_ADDR,
  input  logic [15:0] WORD_IN,
  input  logic        WORD_VALID,
  output logic        WORD_READY,
  output logic        HALT,
  output logic        CPU_RST,
  output logic [15:0] ADDRESS,
  output logic [15:0] DATA_OUT,
  output logic        DATA_OE,
  output logic        EXT_RAM_RW,
  output logic        EXT_RAM_EN,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [15:0] CHECKSUM
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT,
    S_WRITE,
    S_NEXT,
    S_RELEASE
  } state_t;

  localparam logic [16:0] MAX_LEN  = 17'(MAX_WORDS);
  localparam logic [15:0] RST_LAST = 16'(RST_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic [15:0] csum_q, csum_d;
  logic [15:0] len_q, len_d;
  logic [16:0] idx_q, idx_d;
  logic [15:0] rcnt_q, rcnt_d;
  logic        done_d;
  logic        err_d;
  logic        len_ok;

  assign ADDRESS  = addr_q;
  assign DATA_OUT = data_q;
  assign CHECKSUM = csum_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    csum_d  = csum_q;
    len_d   = len_q;
    idx_d   = idx_q;
    rcnt_d  = rcnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    len_ok  = (LEN != 16'd0) && ({1'b0, LEN} <= MAX_LEN);

    case (state_q)
      S_IDLE: begin
        if (START) begin
          if (len_ok) begin
            len_d   = LEN;
            addr_d  = START_ADDR;
            csum_d  = 16'd0;
            idx_d   = 17'd0;
            state_d = S_ARM;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_ARM: state_d = S_WAIT;
      S_WAIT: begin
        if (WORD_VALID) begin
          data_d  = WORD_IN;
          csum_d  = csum_q + WORD_IN;
          state_d = S_WRITE;
        end
      end
      S_WRITE: state_d = S_NEXT;
      S_NEXT: begin
        // Address moves only after the turnaround cycle so it outlives the enable by one cycle.
        idx_d  = idx_q + 17'd1;
        addr_d = addr_q + 16'd1;
        if (idx_d == {1'b0, len_q}) begin
          rcnt_d  = 16'd0;
          state_d = S_RELEASE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_RELEASE: begin
        if (rcnt_q == RST_LAST) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          rcnt_d = rcnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Every output is a register derived from the next state, so it is valid for the whole state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      addr_q     <= 16'd0;
      data_q     <= 16'd0;
      csum_q     <= 16'd0;
      len_q      <= 16'd0;
      idx_q      <= 17'd0;
      rcnt_q     <= 16'd0;
      WORD_READY <= 1'b0;
      HALT       <= 1'b0;
      CPU_RST    <= 1'b0;
      DATA_OE    <= 1'b0;
      EXT_RAM_RW <= ~RW_WRITE;
      EXT_RAM_EN <= 1'b0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      ERR        <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      csum_q     <= csum_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      rcnt_q     <= rcnt_d;
      WORD_READY <= (state_d == S_WAIT);
      HALT       <= (state_d != S_IDLE);
      CPU_RST    <= (state_d == S_RELEASE);
      DATA_OE    <= (state_d == S_WRITE);
      EXT_RAM_RW <= (state_d == S_WRITE) ? RW_WRITE : ~RW_WRITE;
      EXT_RAM_EN <= (state_d == S_WRITE);
      BUSY       <= (state_d != S_IDLE);
      DONE       <= done_d;
      ERR        <= err_d;
    end
  end

endmodule

// File: tb/tb_bat_amateur_loader.sv
// Directed + randomized bench for bat_amateur_loader; expected RAM image, checksum and
// cycle counts come from a behavioural model of the load.
module tb_bat_amateur_loader;

  logic        CLK = 1'b0;
  logic        RST, START, WORD_VALID;
  logic [15:0] LEN, START_ADDR, WORD_IN;
  logic        WORD_READY, HALT, CPU_RST, DATA_OE, EXT_RAM_RW, EXT_RAM_EN, BUSY, DONE, ERR;
  logic [15:0] ADDRESS, DATA_OUT, CHECKSUM;

  bat_amateur_loader #(.MAX_WORDS(256), .RW_WRITE(1'b1), .RST_CYCLES(2)) dut (
    .CLK(CLK), .RST(RST), .START(START), .LEN(LEN), .START_ADDR(START_ADDR),
    .WORD_IN(WORD_IN), .WORD_VALID(WORD_VALID), .WORD_READY(WORD_READY), .HALT(HALT),
    .CPU_RST(CPU_RST), .ADDRESS(ADDRESS), .DATA_OUT(DATA_OUT), .DATA_OE(DATA_OE),
    .EXT_RAM_RW(EXT_RAM_RW), .EXT_RAM_EN(EXT_RAM_EN), .BUSY(BUSY), .DONE(DONE),
    .ERR(ERR), .CHECKSUM(CHECKSUM)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Bus observer: logs every RAM write and counts protocol events.
  int          en_cnt = 0, busy_cnt = 0, cpurst_cnt = 0, done_cnt = 0, err_cnt = 0, viol = 0;
  logic [15:0] wr_addr_q[$];
  logic [15:0] wr_data_q[$];
  logic        prev_en = 1'b0;
  logic [15:0] prev_addr = 16'd0, prev_data = 16'd0;

  always @(negedge CLK) begin
    if (BUSY) busy_cnt++;
    if (CPU_RST) cpurst_cnt++;
    if (DONE) done_cnt++;
    if (ERR) err_cnt++;
    if (DATA_OE !== EXT_RAM_EN) viol++;
    if (EXT_RAM_EN) begin
      en_cnt++;
      wr_addr_q.push_back(ADDRESS);
      wr_data_q.push_back(DATA_OUT);
      if (prev_en || ADDRESS !== prev_addr || EXT_RAM_RW !== 1'b1 || HALT !== 1'b1) viol++;
    end else if (EXT_RAM_RW !== 1'b0) begin
      viol++;
    end
    if (prev_en && (ADDRESS !== prev_addr || DATA_OUT !== prev_data)) viol++;
    prev_en   = EXT_RAM_EN;
    prev_addr = ADDRESS;
    prev_data = DATA_OUT;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [15:0] wq[$];

  // Runs one complete load and compares it against the model; called at posedge+1.
  task automatic run_load(input logic [15:0] addr, input int len, input int gap_idx,
                          input int gap_len, input bit rand_valid);
    int en0, busy0, rst0, done0, base, i, gapcnt, cyc, nwr;
    bit hs, done_seen, gap_now;
    logic [15:0] sum;
    while (wq.size() < len) wq.push_back(16'($urandom));
    sum = 16'd0;
    for (int k = 0; k < len; k++) sum = sum + wq[k];
    en0 = en_cnt; busy0 = busy_cnt; rst0 = cpurst_cnt; done0 = done_cnt;
    base = wr_addr_q.size();
    START = 1'b1; LEN = 16'(len); START_ADDR = addr; WORD_VALID = 1'b0;
    @(posedge CLK); #1;
    START = 1'b0;
    chk("arm_halt", HALT, 1);
    chk("arm_busy", BUSY, 1);
    chk("arm_addr", ADDRESS, addr);
    i = 0; gapcnt = 0; cyc = 0; done_seen = 1'b0;
    while (!done_seen && cyc < 20 * len + 100) begin
      gap_now    = (i == gap_idx) && (gapcnt < gap_len);
      WORD_VALID = !gap_now && (rand_valid ? ($urandom_range(0, 2) != 0) : 1'b1);
      WORD_IN    = (i < len) ? wq[i] : 16'($urandom);
      @(negedge CLK);
      hs = WORD_VALID && WORD_READY;
      if (gap_now && WORD_READY) begin
        gapcnt++;
        chk("bp_en", EXT_RAM_EN, 0);
        chk("bp_oe", DATA_OE, 0);
        chk("bp_addr", ADDRESS, 16'(addr + i));
      end
      if (DONE) begin
        done_seen = 1'b1;
        chk("done_halt", HALT, 0);
        chk("done_cpurst", CPU_RST, 0);
      end
      @(posedge CLK); #1;
      cyc++;
      if (hs) i++;
    end
    WORD_VALID = 1'b0;
    chk("done_seen", done_seen, 1);
    chk("words_taken", i, len);
    chk("en_pulses", en_cnt - en0, len);
    chk("done_pulses", done_cnt - done0, 1);
    chk("cpurst_cycles", cpurst_cnt - rst0, 2);
    chk("checksum", CHECKSUM, sum);
    if (!rand_valid) chk("load_cycles", busy_cnt - busy0, 1 + 3 * len + 2 + gap_len);
    nwr = wr_addr_q.size() - base;
    chk("wr_count", nwr, len);
    for (int k = 0; k < len && k < nwr; k++) begin
      chk("wr_addr", wr_addr_q[base + k], 16'(addr + k));
      chk("wr_data", wr_data_q[base + k], wq[k]);
    end
    $display("load addr=%h len=%0d csum=%h cycles=%0d", addr, len, CHECKSUM, busy_cnt - busy0);
    wq.delete();
  endtask

  initial begin
    int en0, err0, done0, base, cyc;
    RST = 1'b1; START = 1'b1; LEN = 16'd3; START_ADDR = 16'h0040;
    WORD_IN = 16'd0; WORD_VALID = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0; START = 1'b0;
    chk("rst_halt", HALT, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_cpurst", CPU_RST, 0);
    chk("rst_oe", DATA_OE, 0);
    chk("rst_en", EXT_RAM_EN, 0);
    chk("rst_rw", EXT_RAM_RW, 0);
    chk("rst_ready", WORD_READY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_err", ERR, 0);
    chk("rst_addr", ADDRESS, 0);
    chk("rst_data", DATA_OUT, 0);
    chk("rst_csum", CHECKSUM, 0);
    $display("reset checked");

    wq = '{16'h1234, 16'hABCD, 16'h0001};
    run_load(16'h0010, 3, -1, 0, 1'b0);
    chk("basic_csum", CHECKSUM, 16'hBE02);

    en0 = en_cnt; err0 = err_cnt;
    START = 1'b1; LEN = 16'd0;
    @(posedge CLK); #1;
    START = 1'b0;
    chk("rej0_err", ERR, 1);
    chk("rej0_busy", BUSY, 0);
    chk("rej0_halt", HALT, 0);
    @(posedge CLK); #1;
    chk("rej0_err_clr", ERR, 0);
    START = 1'b1; LEN = 16'd257;
    @(posedge CLK); #1;
    START = 1'b0;
    chk("rej257_err", ERR, 1);
    chk("rej257_busy", BUSY, 0);
    chk("rej257_halt", HALT, 0);
    @(posedge CLK); #1;
    chk("rej_err_count", err_cnt - err0, 2);
    chk("rej_no_en", en_cnt - en0, 0);
    chk("rej_csum_held", CHECKSUM, 16'hBE02);
    $display("rejection len=0 and len=257 checked");

    run_load(16'h0100, 4, 1, 5, 1'b0);
    run_load(16'hFFFF, 2, -1, 0, 1'b0);

    en0 = en_cnt; err0 = err_cnt; done0 = done_cnt; base = wr_addr_q.size();
    START = 1'b1; LEN = 16'd4; START_ADDR = 16'h0200; WORD_VALID = 1'b1; WORD_IN = 16'hC0DE;
    @(posedge CLK); #1;
    START = 1'b0;
    cyc = 0;
    while (en_cnt == en0 && cyc < 50) begin
      @(posedge CLK); #1;
      cyc++;
    end
    chk("abort_first_write", en_cnt - en0, 1);
    WORD_VALID = 1'b0; START = 1'b1; LEN = 16'd0;
    @(posedge CLK); #1;
    START = 1'b0;
    chk("busy_start_err", ERR, 0);
    chk("busy_start_busy", BUSY, 1);
    chk("busy_start_addr", ADDRESS, 16'h0201);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    chk("abort_halt", HALT, 0);
    chk("abort_oe", DATA_OE, 0);
    chk("abort_busy", BUSY, 0);
    chk("abort_en", EXT_RAM_EN, 0);
    chk("abort_addr", ADDRESS, 0);
    chk("abort_csum", CHECKSUM, 0);
    repeat (10) begin
      @(posedge CLK); #1;
    end
    chk("abort_no_done", done_cnt - done0, 0);
    chk("abort_no_err", err_cnt - err0, 0);
    chk("abort_writes", en_cnt - en0, 1);
    if (wr_addr_q.size() > base) begin
      chk("abort_wr_addr", wr_addr_q[base], 16'h0200);
      chk("abort_wr_data", wr_data_q[base], 16'hC0DE);
    end
    $display("abort after first write checked");
    run_load(16'h0300, 5, -1, 0, 1'b0);

    for (int r = 0; r < 4; r++) run_load(16'($urandom), $urandom_range(1, 12), -1, 0, 1'b1);
    run_load(16'h8000, 256, -1, 0, 1'b0);

    chk("bus_protocol", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
